mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
MEM-stage block that consumes the EX/MEM pipeline register outputs and sits on the other end of the EX-stage forwarding interface. It issues data-memory accesses over a req/ack bus with variable latency. It checks address alignment and range, raising AdEL/AdES. It aligns store data and extends load data, drives the MEM-stage forward pair back to EX, and owns the MEM/WB pipeline register.

Parameters:
DM_BASE, 32'h0000_0000, lowest legal data address
DM_SIZE, 32'h0000_3000, byte size of legal data window; addresses in [DM_BASE, DM_BASE+DM_SIZE) are legal

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush of MEM/WB register (exception/eret)
memop_MEM  in  4  decoded memory op (MOP_* codes)
addr_MEM  in  32  effective address (EX ALU result)
wdata_MEM  in  32  store data (forwarded rt)
exc_MEM  in  5  incoming exception code [6:2], 0 = none
regaddr_MEM_i  in  5  destination register, 0 = none
regdata_MEM_i  in  32  result for non-load ops
stall_MEM  out  1  freeze IF..EX/MEM registers
regaddr_MEM  out  5  forward address to EX
regdata_MEM  out  32  forward data to EX
bus_req  out  1  memory request, held until ack
bus_we  out  1  1 = store
bus_addr  out  32  word address, bits[1:0] = 0
bus_be  out  4  byte enables
bus_wdata  out  32  lane-aligned store data
bus_ack  in  1  request accepted/completed; rdata valid this cycle for loads
bus_rdata  in  32  read word
regaddr_WB  out  5  MEM/WB destination register
regdata_WB  out  32  MEM/WB write data
exc_WB  out  5  MEM/WB exception code
badvaddr_WB  out  32  faulting address for AdEL/AdES

Behaviour:
- Reset: state IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, all *_WB outputs=0, drop flag=0. Reset mid-transaction abandons it.
- Checks, in priority order:
  - exc_MEM≠0 passes through unchanged and suppresses the access.
  - Misaligned access faults: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠0.
  - Out-of-range address faults.
  - A faulting load raises AdEL=4; a faulting store raises AdES=5.
  - Any faulted op forces regaddr to 0 and issues no bus access.
- access = memop is a load or store, with no exception.
- FSM, state IDLE:
  - If access, latch bus_addr/we/be/wdata, set lane register = addr[1:0], and go to WAIT. stall_MEM=1 and the MEM/WB register loads a bubble (regaddr 0, exc 0).
  - Otherwise, stall_MEM=0 and MEM/WB loads regaddr_MEM_i/regdata_MEM_i/exception.
- FSM, state WAIT:
  - bus_req=1 from registered fields.
  - No ack: stall_MEM=1 and MEM/WB loads a bubble.
  - On ack: bus_req drops next cycle and the FSM returns to IDLE.
    - stall_MEM=0 this cycle.
    - MEM/WB loads the load-extended rdata, or regaddr 0 for stores.
- Minimum latency is 2 cycles per memory op (ack on the first WAIT cycle). Throughput is 1 op / (1 + wait cycles).
- Store alignment:
  - SB: be = 1<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111.
- Load extension uses the lane register: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Forward outputs are combinational.
  - Non-load ops: regaddr_MEM = regaddr_MEM_i, regdata_MEM = regdata_MEM_i.
  - Loads and faulted ops: regaddr_MEM = 0, because load data is not valid here.
- clr in IDLE: MEM/WB loads a bubble, and no access starts that cycle.
- clr in WAIT: an issued transaction is never cancelled.
  - Set drop; keep bus_req until ack.
  - At ack, MEM/WB loads a bubble and drop clears.
  - stall_MEM follows the normal rule.
- bus_ack in IDLE is ignored.
- badvaddr_WB = addr_MEM when AdEL/AdES is generated here, else 0.

Decomposition:
- Shared header holds:
  - MOP_NONE=0, MOP_LB=1, MOP_LBU=2, MOP_LH=3, MOP_LHU=4, MOP_LW=5, MOP_SB=6, MOP_SH=7, MOP_SW=8, and WIDTH_MOP=4.
  - EXC_ADEL/EXC_ADES, which already exist.
  - FSM state codes.
- One sub-module, mem_lane_align: combinational store be/wdata alignment and load extension.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF, ack after 3 cycles -> bus_be=1111, bus_addr=0x10; stall_MEM high for 3 cycles; 3 bubbles, then the next op enters.
- SB addr 0x13, data 0x000000A5, then LB addr 0x13 with rdata 0xA5000000 -> store be=1000, wdata=0xA5A5A5A5; LB result regdata_WB=0xFFFFFFA5; LBU gives 0x000000A5.
- LH addr 0x21 -> exc_WB=4, badvaddr_WB=0x21, bus_req never asserted, regaddr_WB=0; SW addr 0x3002 -> exc_WB=5.
- ADDU regaddr 8, data 7 -> regaddr_MEM=8, regdata_MEM=7 same cycle, WB next cycle; LW to reg 8 -> regaddr_MEM=0.
- LW issued, clr asserted in WAIT, ack 2 cycles later -> bus_req held until ack; regaddr_WB stays 0; FSM returns to IDLE.
- rst_n pulsed low in WAIT -> bus_req=0 immediately, all *_WB=0, IDLE; exc_MEM=12 (Ov) with SW -> exc_WB=12, no bus access.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: memory op codes,
// address-error exception codes and the access FSM states.
package mem_access_unit_pkg;

   localparam int WIDTH_MOP = 4;

   localparam logic [WIDTH_MOP-1:0] MOP_NONE = 4'd0;
   localparam logic [WIDTH_MOP-1:0] MOP_LB   = 4'd1;
   localparam logic [WIDTH_MOP-1:0] MOP_LBU  = 4'd2;
   localparam logic [WIDTH_MOP-1:0] MOP_LH   = 4'd3;
   localparam logic [WIDTH_MOP-1:0] MOP_LHU  = 4'd4;
   localparam logic [WIDTH_MOP-1:0] MOP_LW   = 4'd5;
   localparam logic [WIDTH_MOP-1:0] MOP_SB   = 4'd6;
   localparam logic [WIDTH_MOP-1:0] MOP_SH   = 4'd7;
   localparam logic [WIDTH_MOP-1:0] MOP_SW   = 4'd8;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mau_state_e;

   function automatic logic mop_is_load(input logic [WIDTH_MOP-1:0] mop);
      return (mop >= MOP_LB) && (mop <= MOP_LW);
   endfunction

   function automatic logic mop_is_store(input logic [WIDTH_MOP-1:0] mop);
      return (mop >= MOP_SB) && (mop <= MOP_SW);
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and
// sign/zero extension of the selected lane of a read word.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [WIDTH_MOP-1:0] st_mop_i,
   input  logic [1:0]           st_lane_i,
   input  logic [31:0]          st_data_i,
   output logic [3:0]           be_o,
   output logic [31:0]          st_data_o,
   input  logic [WIDTH_MOP-1:0] ld_mop_i,
   input  logic [1:0]           ld_lane_i,
   input  logic [31:0]          ld_data_i,
   output logic [31:0]          ld_data_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Loads use the same enables as the store of the same width.
   always_comb begin
      be_o      = 4'b1111;
      st_data_o = st_data_i;
      case (st_mop_i)
         MOP_LB, MOP_LBU, MOP_SB: begin
            be_o      = 4'b0001 << st_lane_i;
            st_data_o = {4{st_data_i[7:0]}};
         end
         MOP_LH, MOP_LHU, MOP_SH: begin
            be_o      = st_lane_i[1] ? 4'b1100 : 4'b0011;
            st_data_o = {2{st_data_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ld_byte = ld_data_i[7:0];
      case (ld_lane_i)
         2'd1:    ld_byte = ld_data_i[15:8];
         2'd2:    ld_byte = ld_data_i[23:16];
         2'd3:    ld_byte = ld_data_i[31:24];
         default: ld_byte = ld_data_i[7:0];
      endcase
      ld_half = ld_lane_i[1] ? ld_data_i[31:16] : ld_data_i[15:0];

      ld_data_o = ld_data_i;
      case (ld_mop_i)
         MOP_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
         MOP_LBU: ld_data_o = {24'd0, ld_byte};
         MOP_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
         MOP_LHU: ld_data_o = {16'd0, ld_half};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: address checks, req/ack data-memory access FSM, EX forward
// pair and the MEM/WB pipeline register.
//
// state   | meaning
// ST_IDLE | no transaction outstanding; non-memory ops pass to WB
// ST_WAIT | bus_req held from registered fields until bus_ack
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter logic [31:0] DM_BASE = 32'h0000_0000,
   parameter logic [31:0] DM_SIZE = 32'h0000_3000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clr,
   input  logic [WIDTH_MOP-1:0] memop_MEM,
   input  logic [31:0]          addr_MEM,
   input  logic [31:0]          wdata_MEM,
   input  logic [4:0]           exc_MEM,
   input  logic [4:0]           regaddr_MEM_i,
   input  logic [31:0]          regdata_MEM_i,
   output logic                 stall_MEM,
   output logic [4:0]           regaddr_MEM,
   output logic [31:0]          regdata_MEM,
   output logic                 bus_req,
   output logic                 bus_we,
   output logic [31:0]          bus_addr,
   output logic [3:0]           bus_be,
   output logic [31:0]          bus_wdata,
   input  logic                 bus_ack,
   input  logic [31:0]          bus_rdata,
   output logic [4:0]           regaddr_WB,
   output logic [31:0]          regdata_WB,
   output logic [4:0]           exc_WB,
   output logic [31:0]          badvaddr_WB
);

   mau_state_e           state_q, state_d;
   logic                 req_q, req_d, we_q, we_d, drop_q, drop_d;
   logic [31:0]          addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0]           be_q, be_d;
   logic [1:0]           lane_q, lane_d;
   logic [WIDTH_MOP-1:0] mop_q, mop_d;
   logic [4:0]           rd_q, rd_d, wb_ra_q, wb_ra_d, wb_exc_q, wb_exc_d;
   logic [31:0]          wb_rd_q, wb_rd_d, wb_bva_q, wb_bva_d;

   logic        is_ld, is_st, misalign, out_of_range, fault, access;
   logic [4:0]  exc_eff;
   logic [3:0]  al_be;
   logic [31:0] al_wdata, ld_ext;

   always_comb begin
      is_ld    = mop_is_load(memop_MEM);
      is_st    = mop_is_store(memop_MEM);
      misalign = (((memop_MEM == MOP_LH) || (memop_MEM == MOP_LHU) || (memop_MEM == MOP_SH))
                  && addr_MEM[0])
              || (((memop_MEM == MOP_LW) || (memop_MEM == MOP_SW)) && (addr_MEM[1:0] != 2'b00));
      // 33-bit compare so a window ending at 2^32 does not wrap.
      out_of_range = ({1'b0, addr_MEM} < {1'b0, DM_BASE})
                  || ({1'b0, addr_MEM} >= ({1'b0, DM_BASE} + {1'b0, DM_SIZE}));
      fault    = (is_ld || is_st) && (exc_MEM == 5'd0) && (misalign || out_of_range);
      access   = (is_ld || is_st) && (exc_MEM == 5'd0) && !fault;
      exc_eff  = (exc_MEM != 5'd0) ? exc_MEM :
                 fault ? (is_ld ? EXC_ADEL : EXC_ADES) : 5'd0;
      regaddr_MEM = (is_ld || (exc_eff != 5'd0)) ? 5'd0 : regaddr_MEM_i;
      regdata_MEM = regdata_MEM_i;
   end

   mem_lane_align u_align (
      .st_mop_i  (memop_MEM),
      .st_lane_i (addr_MEM[1:0]),
      .st_data_i (wdata_MEM),
      .be_o      (al_be),
      .st_data_o (al_wdata),
      .ld_mop_i  (mop_q),
      .ld_lane_i (lane_q),
      .ld_data_i (bus_rdata),
      .ld_data_o (ld_ext)
   );

   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      be_d      = be_q;
      wdata_d   = wdata_q;
      lane_d    = lane_q;
      mop_d     = mop_q;
      rd_d      = rd_q;
      drop_d    = drop_q;
      stall_MEM = 1'b0;
      wb_ra_d   = 5'd0;
      wb_rd_d   = 32'd0;
      wb_exc_d  = 5'd0;
      wb_bva_d  = 32'd0;
      case (state_q)
         ST_IDLE: begin
            if (clr) begin
               stall_MEM = 1'b0;
            end else if (access) begin
               state_d   = ST_WAIT;
               req_d     = 1'b1;
               we_d      = is_st;
               addr_d    = {addr_MEM[31:2], 2'b00};
               be_d      = al_be;
               wdata_d   = al_wdata;
               lane_d    = addr_MEM[1:0];
               mop_d     = memop_MEM;
               rd_d      = regaddr_MEM_i;
               stall_MEM = 1'b1;
            end else begin
               wb_ra_d  = regaddr_MEM;
               wb_rd_d  = regdata_MEM_i;
               wb_exc_d = exc_eff;
               wb_bva_d = fault ? addr_MEM : 32'd0;
            end
         end
         ST_WAIT: begin
            if (clr) drop_d = 1'b1;
            if (!bus_ack) begin
               stall_MEM = 1'b1;
            end else begin
               state_d = ST_IDLE;
               req_d   = 1'b0;
               drop_d  = 1'b0;
               // A flush seen during or at the end of the wait discards the result.
               if (!drop_q && !clr && !we_q) begin
                  wb_ra_d = rd_q;
                  wb_rd_d = ld_ext;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         req_q    <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= 32'd0;
         be_q     <= 4'd0;
         wdata_q  <= 32'd0;
         lane_q   <= 2'd0;
         mop_q    <= MOP_NONE;
         rd_q     <= 5'd0;
         drop_q   <= 1'b0;
         wb_ra_q  <= 5'd0;
         wb_rd_q  <= 32'd0;
         wb_exc_q <= 5'd0;
         wb_bva_q <= 32'd0;
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         be_q     <= be_d;
         wdata_q  <= wdata_d;
         lane_q   <= lane_d;
         mop_q    <= mop_d;
         rd_q     <= rd_d;
         drop_q   <= drop_d;
         wb_ra_q  <= wb_ra_d;
         wb_rd_q  <= wb_rd_d;
         wb_exc_q <= wb_exc_d;
         wb_bva_q <= wb_bva_d;
      end
   end

   assign bus_req     = req_q;
   assign bus_we      = we_q;
   assign bus_addr    = addr_q;
   assign bus_be      = be_q;
   assign bus_wdata   = wdata_q;
   assign regaddr_WB  = wb_ra_q;
   assign regdata_WB  = wb_rd_q;
   assign exc_WB      = wb_exc_q;
   assign badvaddr_WB = wb_bva_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table for single-cycle ops,
// hand sequences for bus transactions, flushes and reset; MEM/WB via scoreboard.
module tb_mem_access_unit;
   import mem_access_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n, clr;
   logic [3:0]  memop_MEM;
   logic [31:0] addr_MEM, wdata_MEM, regdata_MEM_i, bus_rdata;
   logic [4:0]  exc_MEM, regaddr_MEM_i;
   logic        stall_MEM, bus_req, bus_we, bus_ack;
   logic [4:0]  regaddr_MEM, regaddr_WB, exc_WB;
   logic [31:0] regdata_MEM, bus_addr, bus_wdata, regdata_WB, badvaddr_WB;
   logic [3:0]  bus_be;

   always #5 clk = ~clk;

   mem_access_unit dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .memop_MEM(memop_MEM), .addr_MEM(addr_MEM), .wdata_MEM(wdata_MEM),
      .exc_MEM(exc_MEM), .regaddr_MEM_i(regaddr_MEM_i), .regdata_MEM_i(regdata_MEM_i),
      .stall_MEM(stall_MEM), .regaddr_MEM(regaddr_MEM), .regdata_MEM(regdata_MEM),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
      .regaddr_WB(regaddr_WB), .regdata_WB(regdata_WB), .exc_WB(exc_WB),
      .badvaddr_WB(badvaddr_WB)
   );

   typedef struct {
      logic [4:0]  ra;
      logic [31:0] rd;
      logic [4:0]  exc;
      logic [31:0] bva;
   } wb_t;

   typedef struct {
      logic [3:0]  mop;
      logic [31:0] a;
      logic [4:0]  exc;
      logic [4:0]  ra;
      logic [31:0] rd;
      logic [4:0]  f_ra;
      logic [4:0]  w_exc;
      logic [31:0] w_bva;
   } vec_t;

   wb_t  sb_q[$];
   vec_t vt[10];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic wb_t mk(input logic [4:0] ra, input logic [31:0] rd,
                              input logic [4:0] exc, input logic [31:0] bva);
      wb_t w;
      w.ra = ra; w.rd = rd; w.exc = exc; w.bva = bva;
      return w;
   endfunction

   task automatic tick();
      wb_t e;
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("wb_regaddr", {27'd0, regaddr_WB}, {27'd0, e.ra});
         chk("wb_regdata", regdata_WB, e.rd);
         chk("wb_exc", {27'd0, exc_WB}, {27'd0, e.exc});
         chk("wb_badvaddr", badvaddr_WB, e.bva);
      end
   endtask

   task automatic drive(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] wd,
                        input logic [4:0] exc, input logic [4:0] ra, input logic [31:0] rd);
      memop_MEM = mop; addr_MEM = a; wdata_MEM = wd;
      exc_MEM = exc; regaddr_MEM_i = ra; regdata_MEM_i = rd;
   endtask

   task automatic do_mem(input logic [3:0] mop, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] ra, input int nwait, input logic [31:0] rdat,
                         input logic chk_bus, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_res);
      logic st;
      st = (mop >= MOP_SB);
      drive(mop, a, wd, 5'd0, ra, 32'd0);
      clr = 1'b0; bus_ack = 1'b0;
      #1;
      chk("issue_stall", {31'd0, stall_MEM}, 32'd1);
      chk("issue_fwd_ra", {27'd0, regaddr_MEM}, st ? {27'd0, ra} : 32'd0);
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      chk("bus_req", {31'd0, bus_req}, 32'd1);
      chk("bus_addr", bus_addr, a & 32'hFFFF_FFFC);
      chk("bus_we", {31'd0, bus_we}, {31'd0, st});
      if (chk_bus) begin
         chk("bus_be", {28'd0, bus_be}, {28'd0, e_be});
         chk("bus_wdata", bus_wdata, e_wd);
      end
      for (int i = 0; i < nwait; i++) begin
         #1;
         chk("wait_stall", {31'd0, stall_MEM}, 32'd1);
         sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
         tick();
         chk("wait_req", {31'd0, bus_req}, 32'd1);
      end
      bus_ack = 1'b1; bus_rdata = rdat;
      #1;
      chk("ack_stall", {31'd0, stall_MEM}, 32'd0);
      sb_q.push_back(st ? mk(5'd0, 32'd0, 5'd0, 32'd0) : mk(ra, e_res, 5'd0, 32'd0));
      tick();
      bus_ack = 1'b0;
      drive(MOP_NONE, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);
      chk("req_drop", {31'd0, bus_req}, 32'd0);
   endtask

   initial begin
      //          mop        addr           exc    ra     rd      f_ra   w_exc  w_bva
      vt[0] = '{MOP_NONE, 32'h0000_0000, 5'd0,  5'd8, 32'd7,  5'd8, 5'd0,  32'h0};
      vt[1] = '{MOP_LH,   32'h0000_0021, 5'd0,  5'd5, 32'd0,  5'd0, 5'd4,  32'h21};
      vt[2] = '{MOP_SW,   32'h0000_3002, 5'd0,  5'd0, 32'd0,  5'd0, 5'd5,  32'h3002};
      vt[3] = '{MOP_SW,   32'h0000_3000, 5'd0,  5'd0, 32'd0,  5'd0, 5'd5,  32'h3000};
      vt[4] = '{MOP_LW,   32'h0000_2FFD, 5'd0,  5'd6, 32'd0,  5'd0, 5'd4,  32'h2FFD};
      vt[5] = '{MOP_SW,   32'h0000_0010, 5'd12, 5'd0, 32'd0,  5'd0, 5'd12, 32'h0};
      vt[6] = '{MOP_LB,   32'h0000_3000, 5'd0,  5'd7, 32'd0,  5'd0, 5'd4,  32'h3000};
      vt[7] = '{MOP_NONE, 32'h0000_0000, 5'd0,  5'd0, 32'd5,  5'd0, 5'd0,  32'h0};
      vt[8] = '{MOP_NONE, 32'h0000_5000, 5'd0,  5'd3, 32'h11, 5'd3, 5'd0,  32'h0};
      vt[9] = '{MOP_LBU,  32'hFFFF_FFFF, 5'd0,  5'd2, 32'd0,  5'd0, 5'd4,  32'hFFFF_FFFF};

      clr = 1'b0; bus_ack = 1'b0; bus_rdata = 32'd0;
      drive(MOP_NONE, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_req", {31'd0, bus_req}, 32'd0);
      chk("rst_we", {31'd0, bus_we}, 32'd0);
      chk("rst_addr", bus_addr, 32'd0);
      chk("rst_be", {28'd0, bus_be}, 32'd0);
      chk("rst_wdata", bus_wdata, 32'd0);
      chk("rst_wb_ra", {27'd0, regaddr_WB}, 32'd0);
      chk("rst_wb_rd", regdata_WB, 32'd0);
      chk("rst_wb_exc", {27'd0, exc_WB}, 32'd0);
      chk("rst_wb_bva", badvaddr_WB, 32'd0);
      #19 rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vt[i]) begin
         drive(vt[i].mop, vt[i].a, 32'h1234_5678, vt[i].exc, vt[i].ra, vt[i].rd);
         #1;
         chk("vec_fwd_ra", {27'd0, regaddr_MEM}, {27'd0, vt[i].f_ra});
         chk("vec_fwd_rd", regdata_MEM, vt[i].rd);
         chk("vec_stall", {31'd0, stall_MEM}, 32'd0);
         sb_q.push_back(mk(vt[i].f_ra, vt[i].rd, vt[i].w_exc, vt[i].w_bva));
         tick();
         chk("vec_no_req", {31'd0, bus_req}, 32'd0);
      end

      // ack while idle must be ignored
      drive(MOP_NONE, 32'd0, 32'd0, 5'd0, 5'd4, 32'h55);
      bus_ack = 1'b1;
      sb_q.push_back(mk(5'd4, 32'h55, 5'd0, 32'd0));
      tick();
      chk("idle_ack_req", {31'd0, bus_req}, 32'd0);
      bus_ack = 1'b0;

      do_mem(MOP_SW,  32'h10,   32'hDEAD_BEEF, 5'd0,  2, 32'd0,         1'b1, 4'b1111, 32'hDEAD_BEEF, 32'd0);
      do_mem(MOP_SB,  32'h13,   32'h0000_00A5, 5'd0,  0, 32'd0,         1'b1, 4'b1000, 32'hA5A5_A5A5, 32'd0);
      do_mem(MOP_LB,  32'h13,   32'd0,         5'd9,  0, 32'hA500_0000, 1'b0, 4'b0,    32'd0, 32'hFFFF_FFA5);
      do_mem(MOP_LBU, 32'h13,   32'd0,         5'd9,  1, 32'hA500_0000, 1'b0, 4'b0,    32'd0, 32'h0000_00A5);
      do_mem(MOP_SH,  32'h22,   32'h0000_1234, 5'd0,  0, 32'd0,         1'b1, 4'b1100, 32'h1234_1234, 32'd0);
      do_mem(MOP_SH,  32'h20,   32'hFFFF_8765, 5'd0,  0, 32'd0,         1'b1, 4'b0011, 32'h8765_8765, 32'd0);
      do_mem(MOP_LH,  32'h12,   32'd0,         5'd10, 0, 32'h8001_0000, 1'b0, 4'b0,    32'd0, 32'hFFFF_8001);
      do_mem(MOP_LHU, 32'h12,   32'd0,         5'd10, 0, 32'h8001_0000, 1'b0, 4'b0,    32'd0, 32'h0000_8001);
      do_mem(MOP_LW,  32'h20,   32'd0,         5'd8,  1, 32'h1234_5678, 1'b0, 4'b0,    32'd0, 32'h1234_5678);
      do_mem(MOP_SB,  32'h2FFF, 32'h0000_007F, 5'd0,  0, 32'd0,         1'b1, 4'b1000, 32'h7F7F_7F7F, 32'd0);
      do_mem(MOP_LB,  32'h11,   32'd0,         5'd4,  0, 32'h0000_8000, 1'b0, 4'b0,    32'd0, 32'hFFFF_FF80);

      // flush during an outstanding load: bus held, result discarded
      drive(MOP_LW, 32'h24, 32'd0, 5'd0, 5'd5, 32'd0);
      #1;
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      clr = 1'b1;
      #1;
      chk("clr_wait_stall", {31'd0, stall_MEM}, 32'd1);
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      clr = 1'b0;
      chk("clr_hold_req", {31'd0, bus_req}, 32'd1);
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      chk("clr_hold_req2", {31'd0, bus_req}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      #1;
      chk("clr_ack_stall", {31'd0, stall_MEM}, 32'd0);
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      bus_ack = 1'b0;
      chk("clr_req_drop", {31'd0, bus_req}, 32'd0);
      drive(MOP_NONE, 32'd0, 32'd0, 5'd0, 5'd3, 32'd1);
      #1;
      chk("clr_idle_stall", {31'd0, stall_MEM}, 32'd0);
      sb_q.push_back(mk(5'd3, 32'd1, 5'd0, 32'd0));
      tick();

      // flush while idle: no access starts
      drive(MOP_SW, 32'h40, 32'hCAFE_F00D, 5'd0, 5'd0, 32'd0);
      clr = 1'b1;
      #1;
      chk("clr_idle_nostall", {31'd0, stall_MEM}, 32'd0);
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      chk("clr_idle_noreq", {31'd0, bus_req}, 32'd0);
      clr = 1'b0;
      drive(MOP_NONE, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);

      // reset in the middle of a transaction
      drive(MOP_LW, 32'h30, 32'd0, 5'd0, 5'd6, 32'd0);
      #1;
      sb_q.push_back(mk(5'd0, 32'd0, 5'd0, 32'd0));
      tick();
      chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", {31'd0, bus_req}, 32'd0);
      chk("mid_rst_addr", bus_addr, 32'd0);
      chk("mid_rst_be", {28'd0, bus_be}, 32'd0);
      chk("mid_rst_wb_ra", {27'd0, regaddr_WB}, 32'd0);
      chk("mid_rst_wb_exc", {27'd0, exc_WB}, 32'd0);
      drive(MOP_NONE, 32'd0, 32'd0, 5'd0, 5'd4, 32'd9);
      rst_n = 1'b1;
      #1;
      chk("post_rst_stall", {31'd0, stall_MEM}, 32'd0);
      sb_q.push_back(mk(5'd4, 32'd9, 5'd0, 32'd0));
      tick();
      chk("post_rst_req", {31'd0, bus_req}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
